sap_ram_gen2: RTL and testbench

SAP_RAM_GEN2 -- requirements
Module: sap_ram_gen2

---
 rtl/sap_ram_gen2.sv | 161 ++++++++++++++++
 tb/tb_sap_ram_gen2.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sap_ram_gen2.sv
// sap_ram_gen2: SAP-style bus RAM with an address register, bus write/read,
// post-increment, a whole-memory clear sequencer and a front-panel programming
// handshake.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   address_enable           load address register from DATA[ADDR_W-1:0]
//   write_enable             write DATA to memory[address register]
//   output_enable            drive memory[address register] onto DATA
//   inc_enable               post-increment the address register
//   clear_req                start a whole-memory clear
//   prog_mode/req/addr/data  front-panel programming inputs
//   prog_ack                 programming handshake acknowledge
//   DATA                     shared bidirectional system bus
//   ADDR_OUT, DATA_OUT       display address and memory[ADDR_OUT]
//   busy, bus_error          not in RUN; sticky bus conflict flag
module sap_ram_gen2 #(
  parameter int    DATA_W        = 8,
  parameter int    ADDR_W        = 4,
  parameter string MEM_INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              address_enable,
  input  logic              write_enable,
  input  logic              output_enable,
  input  logic              inc_enable,
  input  logic              clear_req,
  input  logic              prog_mode,
  input  logic              prog_req,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic              prog_ack,
  inout  wire  [DATA_W-1:0] DATA,
  output logic [ADDR_W-1:0] ADDR_OUT,
  output logic [DATA_W-1:0] DATA_OUT,
  output logic              busy,
  output logic              bus_error
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {RUN, CLEAR, PROG_IDLE, PROG_ACK} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic                prog_ack_q, prog_ack_d;
  logic                bus_error_q, bus_error_d;

  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic                mem_we_d;
  logic [ADDR_W-1:0]   mem_waddr_d;
  logic [DATA_W-1:0]   mem_wdata_d;
  logic                bus_drive;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      addr_q      <= '0;
      clr_cnt_q   <= '0;
      prog_ack_q  <= 1'b0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      clr_cnt_q   <= clr_cnt_d;
      prog_ack_q  <= prog_ack_d;
      bus_error_q <= bus_error_d;
    end
  end

  // Memory has no reset; the write is blocked while rst is held so that an
  // aborted clear leaves the untouched words intact.
  always @(posedge clk) begin
    if (mem_we_d && !rst) begin
      mem_q[mem_waddr_d] <= mem_wdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    clr_cnt_d   = clr_cnt_q;
    prog_ack_d  = prog_ack_q;
    bus_error_d = bus_error_q;
    mem_we_d    = 1'b0;
    mem_waddr_d = addr_q;
    mem_wdata_d = DATA;
    unique case (state_q)
      RUN: begin
        // Read and write at once would fight over the bus: neither happens.
        if (output_enable && write_enable) begin
          bus_error_d = 1'b1;
        end
        if (address_enable) begin
          addr_d = DATA[ADDR_W-1:0];
        end else begin
          if (write_enable && !output_enable) begin
            mem_we_d = 1'b1;
          end
          if (inc_enable) begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end
        if (prog_mode) begin
          state_d = PROG_IDLE;
        end else if (clear_req) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
        end
      end
      CLEAR: begin
        mem_we_d    = 1'b1;
        mem_waddr_d = clr_cnt_q;
        mem_wdata_d = '0;
        clr_cnt_d   = clr_cnt_q + ADDR_W'(1);
        if (clr_cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d = RUN;
        end
      end
      PROG_IDLE: begin
        if (prog_req) begin
          mem_we_d    = 1'b1;
          mem_waddr_d = prog_addr;
          mem_wdata_d = prog_data;
          prog_ack_d  = 1'b1;
          state_d     = PROG_ACK;
        end else if (!prog_mode) begin
          state_d = RUN;
        end
      end
      PROG_ACK: begin
        // The write already happened on entry; a long prog_req only holds ack.
        if (!prog_req) begin
          prog_ack_d = 1'b0;
          state_d    = PROG_IDLE;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_comb begin
    unique case (state_q)
      CLEAR:               ADDR_OUT = clr_cnt_q;
      PROG_IDLE, PROG_ACK: ADDR_OUT = prog_addr;
      default:             ADDR_OUT = addr_q;
    endcase
  end

  assign bus_drive = (state_q == RUN) && output_enable && !write_enable && !rst;
  assign DATA      = bus_drive ? mem_q[addr_q] : {DATA_W{1'bz}};
  assign DATA_OUT  = mem_q[ADDR_OUT];
  assign busy      = (state_q != RUN);
  assign prog_ack  = prog_ack_q;
  assign bus_error = bus_error_q;

endmodule

// File: tb/tb_sap_ram_gen2.sv
module tb_sap_ram_gen2;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              address_enable, write_enable, output_enable, inc_enable;
  logic              clear_req, prog_mode, prog_req;
  logic [ADDR_W-1:0] prog_addr;
  logic [DATA_W-1:0] prog_data;
  logic              prog_ack;
  wire  [DATA_W-1:0] DATA;
  logic [ADDR_W-1:0] ADDR_OUT;
  logic [DATA_W-1:0] DATA_OUT;
  logic              busy, bus_error;

  logic [DATA_W-1:0] drv;
  logic              drv_en;
  assign DATA = drv_en ? drv : {DATA_W{1'bz}};

  // Reference model: memory image, address register, sticky error.
  logic [DATA_W-1:0] m_mem [DEPTH];
  logic [ADDR_W-1:0] m_addr;
  logic              m_err;

  int tests = 0;
  int fails = 0;

  sap_ram_gen2 #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_INIT_FILE("")) dut (
    .clk(clk), .rst(rst),
    .address_enable(address_enable), .write_enable(write_enable),
    .output_enable(output_enable), .inc_enable(inc_enable),
    .clear_req(clear_req), .prog_mode(prog_mode), .prog_req(prog_req),
    .prog_addr(prog_addr), .prog_data(prog_data), .prog_ack(prog_ack),
    .DATA(DATA), .ADDR_OUT(ADDR_OUT), .DATA_OUT(DATA_OUT),
    .busy(busy), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ctrl();
    address_enable = 1'b0; write_enable = 1'b0; output_enable = 1'b0;
    inc_enable = 1'b0; drv_en = 1'b0; drv = '0;
  endtask

  // One RUN-state bus cycle: the bench drives DATA unless the RAM should.
  task automatic run_cycle(input string tag, input logic ae, input logic we,
                           input logic oe, input logic inc, input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] exp_bus;
    address_enable = ae; write_enable = we; output_enable = oe; inc_enable = inc;
    if (oe && !we) begin
      drv_en = 1'b0;
    end else begin
      drv_en = 1'b1;
      drv    = d;
    end
    #1;
    exp_bus = (oe && !we) ? m_mem[m_addr] : d;
    check({tag, ".bus"}, DATA, exp_bus);
    tick();
    if (oe && we) m_err = 1'b1;
    if (ae) begin
      m_addr = exp_bus[ADDR_W-1:0];
    end else begin
      if (we && !oe) m_mem[m_addr] = exp_bus;
      if (inc) m_addr = m_addr + 1'b1;
    end
    idle_ctrl();
    check({tag, ".addr_out"}, ADDR_OUT, m_addr);
    check({tag, ".data_out"}, DATA_OUT, m_mem[m_addr]);
    check({tag, ".bus_error"}, bus_error, m_err);
  endtask

  task automatic peek(input logic [ADDR_W-1:0] a);
    run_cycle("peek", 1'b1, 1'b0, 1'b0, 1'b0, DATA_W'(a));
  endtask

  initial begin
    rst = 1'b1;
    clear_req = 1'b0; prog_mode = 1'b0; prog_req = 1'b0;
    prog_addr = '0; prog_data = '0;
    idle_ctrl();
    m_addr = '0; m_err = 1'b0;
    #1;
    check("rst.busy", busy, 1'b0);
    check("rst.addr_out", ADDR_OUT, 4'd0);
    check("rst.bus_error", bus_error, 1'b0);
    check("rst.prog_ack", prog_ack, 1'b0);
    tick();
    tick();
    rst = 1'b0;

    // Preload every word with 0xFF using write + post-increment.
    address_enable = 1'b1; drv_en = 1'b1; drv = 8'h00;
    tick();
    address_enable = 1'b0; write_enable = 1'b1; inc_enable = 1'b1; drv = 8'hFF;
    for (int i = 0; i < DEPTH; i++) tick();
    idle_ctrl();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'hFF;
    m_addr = '0;
    check("preload.addr_wrap", ADDR_OUT, 4'd0);

    // Reset after six clear cycles.
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    check("clr6.busy", busy, 1'b1);
    check("clr6.cnt0", ADDR_OUT, 4'd0);
    for (int i = 0; i < 6; i++) tick();
    check("clr6.cnt6", ADDR_OUT, 4'd6);
    rst = 1'b1;
    #1;
    check("clr6.rst_busy", busy, 1'b0);
    check("clr6.rst_addr", ADDR_OUT, 4'd0);
    check("clr6.rst_ack", prog_ack, 1'b0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) m_mem[i] = 8'h00;
    m_addr = '0;
    for (int a = 0; a < DEPTH; a++) peek(ADDR_W'(a));

    // Full clear with bus controls toggling that must be ignored.
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    address_enable = 1'b1; write_enable = 1'b1; inc_enable = 1'b1;
    drv_en = 1'b1; drv = 8'hAA;
    for (int i = 0; i < DEPTH; i++) begin
      check("clear.busy", busy, 1'b1);
      check("clear.cnt", ADDR_OUT, i[ADDR_W-1:0]);
      tick();
    end
    idle_ctrl();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
    check("clear.done_busy", busy, 1'b0);
    check("clear.addr_kept", ADDR_OUT, m_addr);
    for (int a = 0; a < DEPTH; a++) peek(ADDR_W'(a));

    // clear_req together with prog_mode: programming wins, memory untouched.
    run_cycle("cp.load", 1'b1, 1'b0, 1'b0, 1'b0, 8'h04);
    run_cycle("cp.wr", 1'b0, 1'b1, 1'b0, 1'b0, 8'hC3);
    prog_addr = 4'd4; clear_req = 1'b1; prog_mode = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("cp.busy", busy, 1'b1);
      check("cp.addr_out", ADDR_OUT, 4'd4);
      check("cp.data_out", DATA_OUT, 8'hC3);
    end
    clear_req = 1'b0; prog_mode = 1'b0;
    tick();
    check("cp.run", busy, 1'b0);
    peek(4'd4);
    peek(4'd0);

    // Bus write then read.
    run_cycle("wr_rd.load", 1'b1, 1'b0, 1'b0, 1'b0, 8'h05);
    run_cycle("wr_rd.wr", 1'b0, 1'b1, 1'b0, 1'b0, 8'hA7);
    run_cycle("wr_rd.rd", 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    check("wr_rd.addr5", ADDR_OUT, 4'd5);

    // Auto-increment wrap.
    run_cycle("wrap.load", 1'b1, 1'b0, 1'b0, 1'b0, 8'h0F);
    run_cycle("wrap.wr_inc", 1'b0, 1'b1, 1'b0, 1'b1, 8'h3C);
    check("wrap.addr0", ADDR_OUT, 4'd0);
    run_cycle("wrap.inc", 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    check("wrap.addr1", ADDR_OUT, 4'd1);
    run_cycle("wrap.ae_inc", 1'b1, 1'b0, 1'b0, 1'b1, 8'h08);
    check("wrap.load_only", ADDR_OUT, 4'd8);
    peek(4'd15);

    // Bus conflict.
    run_cycle("conf.load", 1'b1, 1'b0, 1'b0, 1'b0, 8'h02);
    run_cycle("conf.wr", 1'b0, 1'b1, 1'b0, 1'b0, 8'h11);
    run_cycle("conf.ff", 1'b0, 1'b1, 1'b1, 1'b0, 8'hFF);
    run_cycle("conf.00", 1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    check("conf.flag", bus_error, 1'b1);
    run_cycle("conf.idle", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    peek(4'd2);
    rst = 1'b1;
    #1;
    check("conf.rst_clears", bus_error, 1'b0);
    tick();
    rst = 1'b0;
    m_err = 1'b0; m_addr = '0;

    // Programming handshake with prog_req held four cycles.
    run_cycle("prog.load", 1'b1, 1'b0, 1'b0, 1'b0, 8'h07);
    prog_mode = 1'b1;
    tick();
    check("prog.idle_busy", busy, 1'b1);
    check("prog.idle_ack", prog_ack, 1'b0);
    prog_addr = 4'd9; prog_data = 8'h5A; prog_req = 1'b1;
    address_enable = 1'b1; write_enable = 1'b1; drv_en = 1'b1; drv = 8'h03;
    tick();
    check("prog.ack", prog_ack, 1'b1);
    check("prog.addr_out", ADDR_OUT, 4'd9);
    check("prog.data_out", DATA_OUT, 8'h5A);
    prog_data = 8'h77;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("prog.ack_hold", prog_ack, 1'b1);
      check("prog.one_write", DATA_OUT, 8'h5A);
    end
    prog_req = 1'b0;
    tick();
    check("prog.ack_drop", prog_ack, 1'b0);
    check("prog.still_busy", busy, 1'b1);
    idle_ctrl();
    prog_mode = 1'b0;
    tick();
    check("prog.exit_busy", busy, 1'b0);
    check("prog.addr_kept", ADDR_OUT, 4'd7);
    m_mem[9] = 8'h5A;
    peek(4'd9);
    peek(4'd7);
    peek(4'd3);

    // Randomized RUN-state traffic against the model.
    for (int n = 0; n < 300; n++) begin
      run_cycle("rand", ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 2) == 0), $urandom_range(0, 1) == 1,
                DATA_W'($urandom));
    end
    for (int a = 0; a < DEPTH; a++) peek(ADDR_W'(a));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
